// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter for NUM_REQ requesters that share one synchronous
//   FIFO. It grants one requester at a time. That requester may then push up to
//   MAX_BURST words back to back. An IDLE cycle always separates two grants, and
//   the arbiter uses that cycle to pick the next owner. The search for the next
//   owner starts one index above the last owner.
//
// Ports
//   clk_i           clock; all state updates on the rising edge
//   rst_ni          asynchronous active-low reset
//   req_i           per-requester push request (bit i = requester i)
//   req_data_i      flat data bus; requester i owns [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o           one-hot or zero; requester's word accepted this cycle
//   fifo_push_o     push strobe to the shared FIFO
//   fifo_wr_data_o  owner's data slice, driven every cycle
//   fifo_full_i     full flag from the shared FIFO
//   busy_o          high while a grant is held
//   owner_o         index of the current or last granted requester
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NUM_REQ-1:0]                             req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                  req_data_i,
    output logic [NUM_REQ-1:0]                             gnt_o,
    output logic                                           fifo_push_o,
    output logic [DATA_WIDTH-1:0]                          fifo_wr_data_o,
    input  logic                                           fifo_full_i,
    output logic                                           busy_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner_o
);

    localparam int unsigned OwnerW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SumW   = OwnerW + 1;
    localparam int unsigned CntW   = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0]   MaxCnt    = CntW'(MAX_BURST);
    localparam logic [OwnerW-1:0] LastIdx   = OwnerW'(NUM_REQ - 1);
    localparam logic [SumW-1:0]   NumReqSum = SumW'(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [OwnerW-1:0] owner_q, owner_d;
    logic [OwnerW-1:0] last_owner_q, last_owner_d;
    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CntW-1:0]   burst_inc;

    logic              pick_valid;
    logic [OwnerW-1:0] pick_idx;
    logic [SumW-1:0]   cand;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating priority search. Candidates are last_owner+1, +2, ... modulo
    // NUM_REQ, so the last owner itself is considered last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = {1'b0, last_owner_q} + SumW'(i);
            if (cand >= NumReqSum) begin
                cand = cand - NumReqSum;
            end
            if (!pick_valid && req_i[cand[OwnerW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[OwnerW-1:0];
            end
        end
    end

    assign burst_inc = burst_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        gnt_o        = '0;
        fifo_push_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid && !fifo_full_i) begin
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                if (req_i[owner_q]) begin
                    // When req is high but the FIFO is full, stall: hold
                    // the count and do not push.
                    if (!fifo_full_i) begin
                        gnt_o[owner_q] = 1'b1;
                        fifo_push_o    = 1'b1;
                        if (burst_cnt_q != MaxCnt) begin
                            burst_cnt_d = burst_inc;
                        end
                        if (burst_inc == MaxCnt) begin
                            state_d      = StIdle;
                            last_owner_d = owner_q;
                        end
                    end
                end else begin
                    state_d      = StIdle;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= LastIdx;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign fifo_wr_data_o = slice[owner_q];
    assign busy_o         = (state_q == StGrant);
    assign owner_o        = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic         push;
    logic [31:0]  wdata;
    logic         full;
    logic         busy;
    logic [1:0]   owner;

    int tests;
    int fails;

    logic [31:0] exp_data [4];

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(32),
        .MAX_BURST (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .req_data_i    (req_data),
        .gnt_o         (gnt),
        .fifo_push_o   (push),
        .fifo_wr_data_o(wdata),
        .fifo_full_i   (full),
        .busy_o        (busy),
        .owner_o       (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Protocol invariants checked every cycle, away from the active edge.
    always @(negedge clk) begin
        tests++;
        if (!$onehot0(gnt) || (push !== (|gnt)) || (push && full) ||
            (!rst_n && (gnt !== 4'b0000 || push !== 1'b0))) begin
            fails++;
            $display("FAIL invariant t=%0t: gnt=%b push=%b full=%b rst_n=%b, need gnt one-hot/zero, push=|gnt, no push when full or in reset",
                     $time, gnt, push, full, rst_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL reset_state: got gnt=%b push=%b busy=%b owner=%0d, want 0000/0/0/0",
                     gnt, push, busy, owner);
        end
        tick();
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL reset_held_edge: got gnt=%b push=%b busy=%b owner=%0d, want 0000/0/0/0",
                     gnt, push, busy, owner);
        end
    endtask

    // All four requesting: bursts of 4 with one idle cycle between, 0..3 then wrap.
    task automatic test_round_robin();
        logic [3:0] eg;
        tick();
        rst_n = 1'b1;
        #1;
        tests++;
        if ({push, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rr_arb_cycle: got push=%b busy=%b, want 0/0", push, busy);
        end
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % 4);
            for (int k = 0; k < 4; k++) begin
                tick();
                #1;
                tests++;
                if ({gnt, push, busy, owner} !== {eg, 1'b1, 1'b1, 2'(g % 4)} ||
                    wdata !== exp_data[g % 4]) begin
                    fails++;
                    $display("FAIL rr_push g=%0d k=%0d: got gnt=%b push=%b busy=%b owner=%0d data=%h, want gnt=%b push=1 busy=1 owner=%0d data=%h",
                             g, k, gnt, push, busy, owner, wdata, eg, g % 4, exp_data[g % 4]);
                end
            end
            tick();
            if (g == 4) req = 4'b0000;
            #1;
            tests++;
            if ({gnt, push, busy} !== {4'b0000, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL rr_idle_gap g=%0d: got gnt=%b push=%b busy=%b, want 0000/0/0",
                         g, gnt, push, busy);
            end
        end
    endtask

    task automatic test_single();
        tick();
        req = 4'b0100;
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL single_arb: got gnt=%b push=%b busy=%b owner=%0d, want 0000/0/0/0",
                     gnt, push, busy, owner);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            tests++;
            if ({gnt, push, busy, owner} !== {4'b0100, 1'b1, 1'b1, 2'd2} || wdata !== exp_data[2]) begin
                fails++;
                $display("FAIL single_push k=%0d: got gnt=%b push=%b busy=%b owner=%0d data=%h, want 0100/1/1/2 data=%h",
                         k, gnt, push, busy, owner, wdata, exp_data[2]);
            end
        end
        tick();
        req = 4'b0000;
        #1;
        tests++;
        if ({gnt, push, busy} !== {4'b0000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL single_drop: got gnt=%b push=%b busy=%b, want 0000/0/1", gnt, push, busy);
        end
        tick();
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b0, 2'd2}) begin
            fails++;
            $display("FAIL single_exit: got gnt=%b push=%b busy=%b owner=%0d, want 0000/0/0/2",
                     gnt, push, busy, owner);
        end
    endtask

    task automatic test_stall();
        tick();
        req = 4'b0010;
        #1;
        tests++;
        if ({push, busy, owner} !== {1'b0, 1'b0, 2'd2}) begin
            fails++;
            $display("FAIL stall_arb: got push=%b busy=%b owner=%0d, want 0/0/2", push, busy, owner);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            full = (k == 2) ? 1'b1 : 1'b0;
            if (k == 2) begin
                for (int s = 0; s < 3; s++) begin
                    if (s > 0) tick();
                    #1;
                    tests++;
                    if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b1, 2'd1} ||
                        wdata !== exp_data[1]) begin
                        fails++;
                        $display("FAIL stall_hold s=%0d: got gnt=%b push=%b busy=%b owner=%0d data=%h, want 0000/0/1/1 data=%h",
                                 s, gnt, push, busy, owner, wdata, exp_data[1]);
                    end
                end
                tick();
                full = 1'b0;
            end
            #1;
            tests++;
            if ({gnt, push, busy, owner} !== {4'b0010, 1'b1, 1'b1, 2'd1} || wdata !== exp_data[1]) begin
                fails++;
                $display("FAIL stall_push k=%0d: got gnt=%b push=%b busy=%b owner=%0d data=%h, want 0010/1/1/1 data=%h",
                         k, gnt, push, busy, owner, wdata, exp_data[1]);
            end
        end
        tick();
        req = 4'b0000;
        #1;
        tests++;
        if ({gnt, push, busy} !== {4'b0000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL stall_exit: got gnt=%b push=%b busy=%b, want 0000/0/0", gnt, push, busy);
        end
    endtask

    task automatic test_full_idle();
        tick();
        req  = 4'b0011;
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            if (k == 2) full = 1'b0;
            #1;
            tests++;
            if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b0, 2'd1}) begin
                fails++;
                $display("FAIL full_idle k=%0d: got gnt=%b push=%b busy=%b owner=%0d, want 0000/0/0/1",
                         k, gnt, push, busy, owner);
            end
        end
        tick();
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0001, 1'b1, 1'b1, 2'd0} || wdata !== exp_data[0]) begin
            fails++;
            $display("FAIL full_idle_push: got gnt=%b push=%b busy=%b owner=%0d data=%h, want 0001/1/1/0 data=%h",
                     gnt, push, busy, owner, wdata, exp_data[0]);
        end
        tick();
        req = 4'b0000;
        #1;
        tests++;
        if ({gnt, push, busy} !== {4'b0000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL full_idle_drop: got gnt=%b push=%b busy=%b, want 0000/0/1", gnt, push, busy);
        end
        tick();
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL full_idle_exit: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        req = 4'b0100;
        #1;
        tests++;
        if ({push, busy, owner} !== {1'b0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL rmid_arb: got push=%b busy=%b owner=%0d, want 0/0/0", push, busy, owner);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            tests++;
            if ({gnt, push, busy, owner} !== {4'b0100, 1'b1, 1'b1, 2'd2}) begin
                fails++;
                $display("FAIL rmid_push k=%0d: got gnt=%b push=%b busy=%b owner=%0d, want 0100/1/1/2",
                         k, gnt, push, busy, owner);
            end
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL rmid_async: got gnt=%b push=%b busy=%b owner=%0d, want 0000/0/0/0",
                     gnt, push, busy, owner);
        end
        req = 4'b1100;
        tick();
        rst_n = 1'b1;
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL rmid_release: got gnt=%b push=%b busy=%b owner=%0d, want 0000/0/0/0",
                     gnt, push, busy, owner);
        end
        tick();
        #1;
        tests++;
        if ({gnt, push, busy, owner} !== {4'b0100, 1'b1, 1'b1, 2'd2} || wdata !== exp_data[2]) begin
            fails++;
            $display("FAIL rmid_first_grant: got gnt=%b push=%b busy=%b owner=%0d data=%h, want 0100/1/1/2 data=%h",
                     gnt, push, busy, owner, wdata, exp_data[2]);
        end
        tick();
        req = 4'b0000;
        tick();
    endtask

    initial begin
        exp_data[0] = 32'hAAAA_0000;
        exp_data[1] = 32'hBBBB_1111;
        exp_data[2] = 32'hCCCC_2222;
        exp_data[3] = 32'hDDDD_3333;
        req_data    = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        full  = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_full_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
